// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS main control unit:
//   - 4-bit state encoding (plain constants so legacy tools and debug
//     scripts can use the raw values seen on state_o)
//   - opcode constants, ALU operation codes, ALU B-source and PC-source
//     encodings
//   - ctrl_t: the bundle of control strobes driven onto the datapath
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_RESET    = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_MEM_ADDR = 4'd3;
  localparam state_t S_MEM_RD   = 4'd4;
  localparam state_t S_MEM_WB   = 4'd5;
  localparam state_t S_MEM_WR   = 4'd6;
  localparam state_t S_EXEC_R   = 4'd7;
  localparam state_t S_R_WB     = 4'd8;
  localparam state_t S_EXEC_I   = 4'd9;
  localparam state_t S_I_WB     = 4'd10;
  localparam state_t S_BRANCH   = 4'd11;
  localparam state_t S_JUMP     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10
  } pc_source_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  // ALU operation for the immediate-arithmetic group (EXEC_I and I_WB).
  function automatic alu_op_e itype_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // States that wait on the memory ready handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// -----------------------------------------------------------------------------
// mc_wait_timer
// Counts cycles spent waiting on memory and flags the last permitted cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at zero next cycle (has priority)
//   run        : advance the count this cycle
//   expired    : count has reached TIMEOUT_CYC-1 (the final waiting cycle)
// -----------------------------------------------------------------------------
module mc_wait_timer #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      // Saturate: on expiry the controller leaves (or re-enters) the wait
      // state, which clears the count anyway.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle MIPS main control unit. Steps each instruction through
// fetch/decode/execute/memory/writeback and drives the shared-datapath
// control strobes. Memory accesses wait on mem_ready_i and are aborted
// after TIMEOUT_CYC cycles (mem_timeout pulse, return to FETCH).
//
// Configuration macro: MC_CTRL_JUMP_EN
//   defined   : opcode 000010 (j) runs the JUMP state (pc_write, pc_source=10)
//   undefined : opcode 000010 is illegal
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   opcode_i        : IR[31:26], stable from DECODE until return to FETCH
//   mem_ready_i     : memory completes the current access this cycle
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
//                   : datapath control strobes
//   illegal_op      : one-cycle pulse, unknown opcode seen in DECODE
//   mem_timeout     : one-cycle pulse, memory wait aborted
//   state_o         : current state, for debug
// -----------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            mem_ready_i,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            illegal_op,
  output logic            mem_timeout,
  output logic [3:0]      state_o
);

  state_t     state_q, state_d;
  state_t     dec_target;
  logic       dec_illegal;
  logic [5:0] op6;
  logic       op_hi_zero;
  logic       expired;
  logic       timeout;
  logic       tmr_clr;
  logic       tmr_run;
  ctrl_t      ctrl;

  assign op6        = opcode_i[5:0];
  // Any set bit above the 6-bit opcode field makes the opcode illegal.
  assign op_hi_zero = ((opcode_i >> 6) == '0);

  // Abort only when the last permitted cycle also sees no ready.
  assign timeout = is_wait_state(state_q) && !mem_ready_i && expired;

  // Restart the count on every entry into a wait state, including the
  // FETCH -> FETCH re-issue after an aborted fetch.
  assign tmr_clr = is_wait_state(state_d) && ((state_d != state_q) || timeout);
  assign tmr_run = is_wait_state(state_q) && !mem_ready_i;

  mc_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .run     (tmr_run),
    .expired (expired)
  );

  // Opcode dispatch target out of DECODE.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    dec_target  = S_FETCH;
    dec_illegal = 1'b1;
    if (op_hi_zero) begin
      case (op6)
        OP_LW, OP_SW: begin
          dec_target  = S_MEM_ADDR;
          dec_illegal = 1'b0;
        end
        OP_RTYPE: begin
          dec_target  = S_EXEC_R;
          dec_illegal = 1'b0;
        end
        OP_BEQ: begin
          dec_target  = S_BRANCH;
          dec_illegal = 1'b0;
        end
        OP_ADDI, OP_ANDI, OP_ORI: begin
          dec_target  = S_EXEC_I;
          dec_illegal = 1'b0;
        end
`ifdef MC_CTRL_JUMP_EN
        OP_J: begin
          dec_target  = S_JUMP;
          dec_illegal = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
                  else if (expired) state_d = S_FETCH;
      S_DECODE:   state_d = dec_target;
      S_MEM_ADDR: state_d = (op6 == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready_i) state_d = S_MEM_WB;
                  else if (expired) state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready_i || expired) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH:
                  state_d = S_FETCH;
`ifdef MC_CTRL_JUMP_EN
      S_JUMP:     state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Control strobes: Moore decode of state_q, plus the ready-qualified
  // fetch strobes and the two pulses.
  always_comb begin
    ctrl             = '0;
    ctrl.mem_timeout = timeout;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.illegal_op = dec_illegal;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = itype_alu_op(op6);
      end
      S_I_WB: begin
        ctrl.alu_op    = itype_alu_op(op6);
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values and the
      // result does not depend on process evaluation order.
      state_q <= state_d;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign mem_timeout   = ctrl.mem_timeout;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed bench for mc_ctrl_fsm. Each instruction is expanded into a list of
// per-cycle steps (inputs to apply and the full output vector expected),
// derived from the instruction's phase sequence and the number of cycles
// memory withholds ready. A compare process checks every played cycle.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode_i = '0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic       illegal_op, mem_timeout;
  logic [3:0] state_o;

  mc_ctrl_fsm #(.OP_W(6), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op, mem_timeout;
  } vec_t;

  typedef enum {P_RESET, P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_RD, P_MEM_WB,
                P_MEM_WR, P_EXEC_R, P_R_WB, P_EXEC_I, P_I_WB, P_BRANCH,
                P_JUMP} phase_e;

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic       rdy;
    vec_t       exp;
  } step_t;

  step_t q[$];
  step_t cur;
  vec_t  dut_v;
  int    n_vec = 0, n_err = 0, step_no = 0;
  int    n_tmo_seen = 0, n_ill_seen = 0;
  logic  idle_rdy = 1'b1;
  event  cmp_ev;

  assign dut_v = {state_o, pc_write, pc_write_cond, iord, mem_read, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, illegal_op, mem_timeout};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] itype_op(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b011;  // andi
      6'b001101: return 3'b100;  // ori
      default:   return 3'b000;  // addi
    endcase
  endfunction

  // Output vector required in a given phase.
  function automatic vec_t exp_of(input phase_e ph, input logic rdy,
                                  input logic [5:0] op, input logic flag);
    vec_t v = '0;
    case (ph)
      P_RESET: v.st = S_RESET;
      P_FETCH: begin
        v.st = S_FETCH; v.mem_read = 1; v.alu_src_b = 2'b01;
        v.ir_write = rdy; v.pc_write = rdy; v.mem_timeout = flag;
      end
      P_DECODE: begin
        v.st = S_DECODE; v.alu_src_b = 2'b11; v.illegal_op = flag;
      end
      P_MEM_ADDR: begin
        v.st = S_MEM_ADDR; v.alu_src_a = 1; v.alu_src_b = 2'b10;
      end
      P_MEM_RD: begin
        v.st = S_MEM_RD; v.mem_read = 1; v.iord = 1; v.mem_timeout = flag;
      end
      P_MEM_WB: begin
        v.st = S_MEM_WB; v.mem_to_reg = 1; v.reg_write = 1;
      end
      P_MEM_WR: begin
        v.st = S_MEM_WR; v.mem_write = 1; v.iord = 1; v.mem_timeout = flag;
      end
      P_EXEC_R: begin
        v.st = S_EXEC_R; v.alu_src_a = 1; v.alu_op = 3'b010;
      end
      P_R_WB: begin
        v.st = S_R_WB; v.reg_dst = 1; v.reg_write = 1;
      end
      P_EXEC_I: begin
        v.st = S_EXEC_I; v.alu_src_a = 1; v.alu_src_b = 2'b10;
        v.alu_op = itype_op(op);
      end
      P_I_WB: begin
        v.st = S_I_WB; v.alu_op = itype_op(op); v.reg_write = 1;
      end
      P_BRANCH: begin
        v.st = S_BRANCH; v.alu_src_a = 1; v.alu_op = 3'b001;
        v.pc_write_cond = 1; v.pc_source = 2'b01;
      end
      P_JUMP: begin
        v.st = S_JUMP; v.pc_write = 1; v.pc_source = 2'b10;
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic push(input phase_e ph, input logic [5:0] op, input logic rdy,
                      input logic flag = 1'b0);
    step_t s;
    s.rst_n = 1'b1;
    s.op    = op;
    s.rdy   = rdy;
    s.exp   = exp_of(ph, rdy, op, flag);
    q.push_back(s);
  endtask

  // A memory phase withholding ready for w cycles: completes if w < T,
  // otherwise aborts on the T-th waiting cycle.
  task automatic mem_phase(input phase_e ph, input logic [5:0] op,
                           input int w, output bit done);
    if (w >= T) begin
      repeat (T - 1) push(ph, op, 1'b0);
      push(ph, op, 1'b0, 1'b1);
      done = 1'b0;
    end else begin
      repeat (w) push(ph, op, 1'b0);
      push(ph, op, 1'b1);
      done = 1'b1;
    end
  endtask

  // Expand one instruction into per-cycle steps.
  task automatic add_instr(input logic [5:0] op, input int fetch_wait,
                           input int mem_wait);
    int w = fetch_wait;
    bit done;
    // Each full run of T unready fetch cycles aborts and re-issues.
    while (w >= T) begin
      repeat (T - 1) push(P_FETCH, op, 1'b0);
      push(P_FETCH, op, 1'b0, 1'b1);
      w -= T;
    end
    repeat (w) push(P_FETCH, op, 1'b0);
    push(P_FETCH, op, 1'b1);
    case (op)
      6'b000000: begin
        push(P_DECODE, op, idle_rdy);
        push(P_EXEC_R, op, idle_rdy);
        push(P_R_WB, op, idle_rdy);
      end
      6'b001000, 6'b001100, 6'b001101: begin
        push(P_DECODE, op, idle_rdy);
        push(P_EXEC_I, op, idle_rdy);
        push(P_I_WB, op, idle_rdy);
      end
      6'b000100: begin
        push(P_DECODE, op, idle_rdy);
        push(P_BRANCH, op, idle_rdy);
      end
      6'b100011: begin
        push(P_DECODE, op, idle_rdy);
        push(P_MEM_ADDR, op, idle_rdy);
        mem_phase(P_MEM_RD, op, mem_wait, done);
        if (done) push(P_MEM_WB, op, idle_rdy);
      end
      6'b101011: begin
        push(P_DECODE, op, idle_rdy);
        push(P_MEM_ADDR, op, idle_rdy);
        mem_phase(P_MEM_WR, op, mem_wait, done);
      end
`ifdef MC_CTRL_JUMP_EN
      6'b000010: begin
        push(P_DECODE, op, idle_rdy);
        push(P_JUMP, op, idle_rdy);
      end
`endif
      default: push(P_DECODE, op, idle_rdy, 1'b1);
    endcase
  endtask

  // Apply queued steps one per cycle at the falling edge; ends 3 time
  // units after the last application so its comparison has completed.
  task automatic play();
    while (q.size() > 0) begin
      @(negedge clk);
      cur         = q.pop_front();
      rst_n       = cur.rst_n;
      opcode_i    = cur.op;
      mem_ready_i = cur.rdy;
      step_no++;
      -> cmp_ev;
    end
    #3;
  endtask

  // Compare process: full output vector on every played cycle.
  initial begin
    forever begin
      @(cmp_ev);
      #2;
      if (mem_timeout === 1'b1) n_tmo_seen++;
      if (illegal_op === 1'b1) n_ill_seen++;
      check($sformatf("step%0d_op%b_st%0d", step_no, cur.op, cur.exp.st),
            32'(dut_v), 32'(cur.exp));
    end
  end

  initial begin
    int t0;
    // Reset held: everything zero.
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", 32'(state_o), 32'h0);
    check("reset_outputs", 32'(dut_v), 32'h0);

    push(P_RESET, 6'b000000, 1'b0);
    play();

    // R-type, ready always 1: 4 cycles.
    add_instr(6'b000000, 0, 0);
    check("rtype_len", 32'(q.size()), 32'd4);
    play();

    // lw with ready low 3 cycles in MEM_RD: 8 cycles.
    idle_rdy = 1'b0;
    add_instr(6'b100011, 0, 3);
    check("lw_wait3_len", 32'(q.size()), 32'd8);
    play();

    // sw never ready: abort on the 16th MEM_WR cycle.
    t0 = n_tmo_seen;
    add_instr(6'b101011, 0, T);
    check("sw_timeout_len", 32'(q.size()), 32'd19);
    play();
    check("sw_timeout_pulses", 32'(n_tmo_seen - t0), 32'd1);

    // ori then andi, then addi with slow fetch, then beq.
    idle_rdy = 1'b1;
    add_instr(6'b001101, 0, 0);
    add_instr(6'b001100, 0, 0);
    idle_rdy = 1'b0;
    add_instr(6'b001000, 3, 0);
    play();
    add_instr(6'b000100, 0, 0);
    check("beq_len", 32'(q.size()), 32'd3);
    play();

    // lw with ready arriving on the final permitted cycle: no timeout.
    t0 = n_tmo_seen;
    add_instr(6'b100011, 0, T - 1);
    check("lw_last_cycle_len", 32'(q.size()), 32'd20);
    play();
    check("lw_last_cycle_no_timeout", 32'(n_tmo_seen - t0), 32'd0);

    // Fetch abort and re-issue, then R-type completes.
    t0 = n_tmo_seen;
    add_instr(6'b000000, T + 2, 0);
    play();
    check("fetch_timeout_pulses", 32'(n_tmo_seen - t0), 32'd1);

    // Illegal opcodes.
    t0 = n_ill_seen;
    idle_rdy = 1'b1;
    add_instr(6'b111111, 0, 0);
    add_instr(6'b000010, 0, 0);
    play();
`ifdef MC_CTRL_JUMP_EN
    check("illegal_pulses", 32'(n_ill_seen - t0), 32'd1);
`else
    check("illegal_pulses", 32'(n_ill_seen - t0), 32'd2);
`endif

    // Reset asserted mid MEM_RD.
    push(P_FETCH, 6'b100011, 1'b1);
    push(P_DECODE, 6'b100011, 1'b1);
    push(P_MEM_ADDR, 6'b100011, 1'b1);
    push(P_MEM_RD, 6'b100011, 1'b0);
    push(P_MEM_RD, 6'b100011, 1'b0);
    play();
    rst_n = 1'b0;
    #1;
    check("async_reset_state", 32'(state_o), 32'h0);
    check("async_reset_outputs", 32'(dut_v), 32'h0);
    push(P_RESET, 6'b100011, 1'b0);
    add_instr(6'b000000, 0, 0);
    play();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
